// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control
//
// Purpose:
//   Counting controller for the datapath. Counts the clock cycles in which the
//   `counting` request is sampled high. When COUNT_MAX such cycles have been
//   seen, it raises `ready`. `ready` stays high until the requester drops
//   `counting`. Low cycles in the middle of a phase pause the count; they do
//   not clear it.
//
// Parameters:
//   COUNT_MAX  Number of sampled-high cycles of `counting` needed before
//              `ready` is raised. Must be >= 1.
//   CNT_W      Counter width. It must be wide enough to hold COUNT_MAX.
//
// Ports:
//   clk       in   Single clock. All state changes on its rising edge.
//   rst       in   Synchronous reset, active low.
//   counting  in   Count request. Sampled on every rising edge.
//   ready     out  Registered. 1 once COUNT_MAX highs have been counted.
// -----------------------------------------------------------------------------
module control #(
    parameter int COUNT_MAX = 16,
    parameter int CNT_W     = $clog2(COUNT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic counting,
    output logic ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state_reg;
    logic [1:0]       r_state_next;
    logic [CNT_W-1:0] r_cnt_reg;
    logic [CNT_W-1:0] r_cnt_next;
    logic             r_ready_reg;
    logic             r_ready_next;

    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt_reg + CNT_ONE;

    always_comb begin
        r_state_next = r_state_reg;
        r_cnt_next   = r_cnt_reg;
        r_ready_next = r_ready_reg;
        case (r_state_reg)
            ST_IDLE: begin
                r_cnt_next   = '0;
                r_ready_next = 1'b0;
                if (counting) begin
                    r_cnt_next = CNT_ONE;
                    // A single-cycle phase completes on the first high.
                    if (CNT_ONE == CNT_LAST) begin
                        r_state_next = ST_DONE;
                        r_ready_next = 1'b1;
                    end else begin
                        r_state_next = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                // A low cycle is a pause: the count and the state are held.
                if (counting) begin
                    r_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == CNT_LAST) begin
                        r_state_next = ST_DONE;
                        r_ready_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // While the request is held, the count stays at COUNT_MAX.
                // It does not wrap and does not start counting again.
                r_cnt_next   = CNT_LAST;
                r_ready_next = 1'b1;
                if (!counting) begin
                    r_state_next = ST_IDLE;
                    r_cnt_next   = '0;
                    r_ready_next = 1'b0;
                end
            end
            default: begin
                // An unused state encoding returns to a clean idle.
                r_state_next = ST_IDLE;
                r_cnt_next   = '0;
                r_ready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_reg <= ST_IDLE;
            r_cnt_reg   <= '0;
            r_ready_reg <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            r_cnt_reg   <= r_cnt_next;
            r_ready_reg <= r_ready_next;
        end
    end

    assign ready = r_ready_reg;

endmodule

// File: tb/tb_control.sv
// -----------------------------------------------------------------------------
// tb_control
//
// Purpose:
//   Self-checking bench for control. It builds two instances:
//     dut16  COUNT_MAX = 16 (the main scenarios)
//     dut1   COUNT_MAX = 1  (single-cycle edge case)
//   Inputs change on the falling edge. `ready` is sampled 1 ns after each
//   rising edge.
// -----------------------------------------------------------------------------
module tb_control;

    logic clk;
    logic rst;
    logic counting;
    logic ready;
    logic rst1;
    logic counting1;
    logic ready1;

    int n_checks;
    int n_pass;

    control #(.COUNT_MAX(16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .counting (counting),
        .ready    (ready)
    );

    control #(.COUNT_MAX(1)) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .counting (counting1),
        .ready    (ready1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Apply one cycle of stimulus to dut16. Inputs change on the falling
    // edge. The task returns 1 ns after the rising edge that samples them.
    task automatic drive(input logic r, input logic c);
        @(negedge clk);
        rst      = r;
        counting = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic r, input logic c);
        @(negedge clk);
        rst1      = r;
        counting1 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp;
        exp = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        n_checks++;
        if (ready !== exp) $display("FAIL reset_assert: ready=%b expected %b", ready, exp);
        else n_pass++;
        $display("reset: asserted 2 cycles, ready=%b", ready);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0);
            n_checks++;
            if (ready !== exp) $display("FAIL reset_idle[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("reset_idle cycle %0d: ready=%b", i, ready);
        end
    endtask

    task automatic test_continuous();
        logic exp;
        drive(1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1);
            exp = (i == 16);
            n_checks++;
            if (ready !== exp) $display("FAIL continuous[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("continuous high %0d: ready=%b", i, ready);
        end
    endtask

    task automatic test_pause();
        logic exp;
        drive(1'b0, 1'b0);
        exp = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1);
            n_checks++;
            if (ready !== exp) $display("FAIL pause_run[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("pause run high %0d: ready=%b", i, ready);
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0);
            n_checks++;
            if (ready !== exp) $display("FAIL pause_low[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("pause low %0d: ready=%b", i, ready);
        end
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1);
            exp = (i == 6);
            n_checks++;
            if (ready !== exp) $display("FAIL pause_resume[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("pause resume high %0d: ready=%b", i, ready);
        end
    endtask

    // Entered from the DONE state that test_pause leaves behind.
    task automatic test_hold_release();
        logic exp;
        exp = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1);
            n_checks++;
            if (ready !== exp) $display("FAIL hold[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("hold %0d: ready=%b", i, ready);
        end
        drive(1'b1, 1'b0);
        exp = 1'b0;
        n_checks++;
        if (ready !== exp) $display("FAIL release: ready=%b expected %b", ready, exp);
        else n_pass++;
        $display("release: ready=%b", ready);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1);
            exp = (i == 16);
            n_checks++;
            if (ready !== exp) $display("FAIL recount[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("recount high %0d: ready=%b", i, ready);
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        drive(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1);
        // Reset takes priority over a high request.
        drive(1'b0, 1'b1);
        exp = 1'b0;
        n_checks++;
        if (ready !== exp) $display("FAIL reset_mid: ready=%b expected %b", ready, exp);
        else n_pass++;
        $display("reset mid-count: ready=%b", ready);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1);
            exp = (i == 16);
            n_checks++;
            if (ready !== exp) $display("FAIL after_reset[%0d]: ready=%b expected %b", i, ready, exp);
            else n_pass++;
            $display("after reset high %0d: ready=%b", i, ready);
        end
        drive(1'b0, 1'b1);
        exp = 1'b0;
        n_checks++;
        if (ready !== exp) $display("FAIL reset_done: ready=%b expected %b", ready, exp);
        else n_pass++;
        $display("reset in done: ready=%b", ready);
        drive(1'b1, 1'b1);
        n_checks++;
        if (ready !== exp) $display("FAIL reset_done_restart: ready=%b expected %b", ready, exp);
        else n_pass++;
        $display("first high after done reset: ready=%b", ready);
    endtask

    task automatic test_count_max_one();
        logic exp;
        drive1(1'b0, 1'b0);
        exp = 1'b0;
        n_checks++;
        if (ready1 !== exp) $display("FAIL max1_reset: ready=%b expected %b", ready1, exp);
        else n_pass++;
        $display("max1 reset: ready=%b", ready1);
        drive1(1'b1, 1'b0);
        n_checks++;
        if (ready1 !== exp) $display("FAIL max1_idle: ready=%b expected %b", ready1, exp);
        else n_pass++;
        $display("max1 idle: ready=%b", ready1);
        drive1(1'b1, 1'b1);
        exp = 1'b1;
        n_checks++;
        if (ready1 !== exp) $display("FAIL max1_first: ready=%b expected %b", ready1, exp);
        else n_pass++;
        $display("max1 first high: ready=%b", ready1);
        drive1(1'b1, 1'b1);
        n_checks++;
        if (ready1 !== exp) $display("FAIL max1_hold: ready=%b expected %b", ready1, exp);
        else n_pass++;
        $display("max1 hold: ready=%b", ready1);
        drive1(1'b1, 1'b0);
        exp = 1'b0;
        n_checks++;
        if (ready1 !== exp) $display("FAIL max1_release: ready=%b expected %b", ready1, exp);
        else n_pass++;
        $display("max1 release: ready=%b", ready1);
        drive1(1'b1, 1'b1);
        exp = 1'b1;
        n_checks++;
        if (ready1 !== exp) $display("FAIL max1_again: ready=%b expected %b", ready1, exp);
        else n_pass++;
        $display("max1 again: ready=%b", ready1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        counting  = 1'b0;
        rst1      = 1'b0;
        counting1 = 1'b0;
        test_reset();
        test_continuous();
        test_pause();
        test_hold_release();
        test_reset_mid();
        test_count_max_one();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
